// File: rtl/fetch_if_id.sv
// Instruction-fetch stage: next-PC selection plus the IF/ID pipeline register.
// Optional perf counters (BubbleCount/StallCount) are enabled by FETCH_PERF_CNT_EN.
module fetch_if_id #(
  parameter logic [31:0] ADDR_LIMIT = 32'd36,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PC,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] NextAddress,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_Valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0] BubbleCount,
  output logic [15:0] StallCount,
`endif
  output logic        Squash
);

  localparam logic [1:0] S_INIT   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_STALL  = 2'd2;
  localparam logic [1:0] S_SQUASH = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        squash_q, squash_d;
  logic [31:0] pc_plus4;
  logic [31:0] addr_sel;
  logic        redirect;
  logic        bubble_load;
  logic        stall_hold;

  assign pc_plus4 = PC + 32'd4;
  assign redirect = Jump | BranchTaken;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    addr_sel = pc_plus4;
    if (state_q == S_INIT)  addr_sel = 32'd0;
    else if (Jump)          addr_sel = JumpTarget;
    else if (BranchTaken)   addr_sel = BranchTarget;
    else if (Stall)         addr_sel = PC;
    NextAddress = (addr_sel > ADDR_LIMIT) ? 32'd0 : addr_sel;
  end

  always_comb begin
    state_d     = S_RUN;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    squash_d    = 1'b0;
    bubble_load = 1'b0;
    stall_hold  = 1'b0;
    if (state_q == S_INIT) begin
      // Single bubble covering the PC register's post-reset hold cycle.
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else if (redirect) begin
      instr_d     = NOP_WORD;
      valid_d     = 1'b0;
      squash_d    = 1'b1;
      state_d     = S_SQUASH;
      bubble_load = 1'b1;
    end else if (Flush) begin
      instr_d     = NOP_WORD;
      valid_d     = 1'b0;
      bubble_load = 1'b1;
    end else if (Stall) begin
      squash_d   = squash_q;
      state_d    = S_STALL;
      stall_hold = 1'b1;
    end else begin
      instr_d = Instruction;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_INIT;
      instr_q  <= NOP_WORD;
      pc4_q    <= 32'd0;
      valid_q  <= 1'b0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      squash_q <= squash_d;
    end
  end

  assign IF_ID_Instruction = instr_q;
  assign IF_ID_PC4         = pc4_q;
  assign IF_ID_Valid       = valid_q;
  assign Squash            = squash_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] bubble_cnt_q, stall_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bubble_cnt_q <= 16'd0;
      stall_cnt_q  <= 16'd0;
    end else begin
      if (bubble_load && bubble_cnt_q != 16'hFFFF) bubble_cnt_q <= bubble_cnt_q + 16'd1;
      if (stall_hold && stall_cnt_q != 16'hFFFF)   stall_cnt_q  <= stall_cnt_q + 16'd1;
    end
  end

  assign BubbleCount = bubble_cnt_q;
  assign StallCount  = stall_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = bubble_load ^ stall_hold;
`endif

endmodule

// File: tb/tb_fetch_if_id.sv
// Directed bench for fetch_if_id: reset, wrap, redirects, stall and flush cases.
module tb_fetch_if_id;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush, BranchTaken, Jump;
  logic [31:0] PC, Instruction, BranchTarget, JumpTarget;
  logic [31:0] NextAddress, IF_ID_Instruction, IF_ID_PC4;
  logic        IF_ID_Valid, Squash;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] BubbleCount, StallCount;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_if_id dut (
    .Clk(Clk), .Reset(Reset), .PC(PC), .Instruction(Instruction),
    .Stall(Stall), .Flush(Flush), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
    .NextAddress(NextAddress), .IF_ID_Instruction(IF_ID_Instruction),
    .IF_ID_PC4(IF_ID_PC4), .IF_ID_Valid(IF_ID_Valid),
`ifdef FETCH_PERF_CNT_EN
    .BubbleCount(BubbleCount), .StallCount(StallCount),
`endif
    .Squash(Squash)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ifid(input string tag, input logic [31:0] ins, input logic [31:0] pc4,
                      input logic v, input logic sq);
    check({tag, ".instr"}, IF_ID_Instruction, ins);
    check({tag, ".pc4"}, IF_ID_PC4, pc4);
    check({tag, ".valid"}, {31'd0, IF_ID_Valid}, {31'd0, v});
    check({tag, ".squash"}, {31'd0, Squash}, {31'd0, sq});
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
    PC = 32'd0; Instruction = 32'h2008_0005; BranchTarget = 32'd0; JumpTarget = 32'd0;

    // Reset held two cycles, then the post-reset bubble
    tick(); tick();
    Reset = 1'b0;
    #1;
    check("rst.na", NextAddress, 32'd0);
    ifid("rst", NOP, 32'd0, 1'b0, 1'b0);
    tick();
    check("init.valid", {31'd0, IF_ID_Valid}, 32'd0);
    check("init.na", NextAddress, 32'd4);
    tick();
    ifid("first", 32'h2008_0005, 32'd4, 1'b1, 1'b0);

    // Sequential advance and wrap above ADDR_LIMIT
    PC = 32'd32; Instruction = 32'hAAAA_0020; #1;
    check("seq32.na", NextAddress, 32'd36);
    tick();
    ifid("seq32", 32'hAAAA_0020, 32'd36, 1'b1, 1'b0);
    PC = 32'd36; Instruction = 32'hAAAA_0024; #1;
    check("wrap.na", NextAddress, 32'd0);
    tick();
    ifid("wrap", 32'hAAAA_0024, 32'd40, 1'b1, 1'b0);

    // Taken branch: one squash bubble, then target instruction
    PC = 32'd16; Instruction = 32'hBAD0_0010; BranchTaken = 1'b1; BranchTarget = 32'd8; #1;
    check("br.na", NextAddress, 32'd8);
    tick();
    ifid("br.bubble", NOP, 32'd40, 1'b0, 1'b1);
    BranchTaken = 1'b0; PC = 32'd8; Instruction = 32'hCCCC_0008; #1;
    check("br.next.na", NextAddress, 32'd12);
    tick();
    ifid("br.target", 32'hCCCC_0008, 32'd12, 1'b1, 1'b0);

    // Jump beats simultaneous branch
    PC = 32'd12; Instruction = 32'hBAD0_000C;
    Jump = 1'b1; JumpTarget = 32'd20; BranchTaken = 1'b1; BranchTarget = 32'd4; #1;
    check("jmp.na", NextAddress, 32'd20);
    tick();
    ifid("jmp.bubble", NOP, 32'd12, 1'b0, 1'b1);
    Jump = 1'b0; BranchTaken = 1'b0; PC = 32'd20; Instruction = 32'hDDDD_0014; #1;
    tick();
    ifid("jmp.target", 32'hDDDD_0014, 32'd24, 1'b1, 1'b0);

    // Three-cycle stall at PC=12, then exactly one capture of the held instruction
    PC = 32'd12; Instruction = 32'hEEEE_000C; Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall.na", NextAddress, 32'd12);
      tick();
      ifid("stall.hold", 32'hDDDD_0014, 32'd24, 1'b1, 1'b0);
    end
    Stall = 1'b0; #1;
    check("unstall.na", NextAddress, 32'd16);
    tick();
    ifid("unstall", 32'hEEEE_000C, 32'd16, 1'b1, 1'b0);
    PC = 32'd16; Instruction = 32'hFFFF_0010; #1;
    tick();
    ifid("after.stall", 32'hFFFF_0010, 32'd20, 1'b1, 1'b0);

    // Flush together with Stall: bubble while the PC holds
    PC = 32'd20; Instruction = 32'h1111_0014; Stall = 1'b1; Flush = 1'b1; #1;
    check("fl_st.na", NextAddress, 32'd20);
    tick();
    ifid("fl_st", NOP, 32'd20, 1'b0, 1'b0);
    Flush = 1'b0;

    // Reset asserted mid-stall
    PC = 32'd24; Instruction = 32'h2222_0018; #1;
    tick();
    Reset = 1'b1; #1;
    tick();
    ifid("rst.stall", NOP, 32'd0, 1'b0, 1'b0);
    check("rst.stall.na", NextAddress, 32'd0);
    Reset = 1'b0; Stall = 1'b0; PC = 32'd0; #1;
    tick();

    // Jump target above the limit wraps to 0
    Jump = 1'b1; JumpTarget = 32'd100; #1;
    check("jmp.wrap.na", NextAddress, 32'd0);
    Jump = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_if_id.md
Name: fetch_if_id

Overview:
- Instruction-fetch stage wrapped around the program counter register.
- Computes the next-address value that drives the PC's Address input, with sequential PC+4, branch and jump redirect, and wrap to 0 above the instruction-memory limit.
- Captures the fetched instruction into the IF/ID pipeline register, with stall, flush and one-cycle squash control.
- Sits between the PC register / instruction memory and the decode stage.

Parameters:
- ADDR_LIMIT, 36: highest legal fetch byte address. Any computed next address above it becomes 0.
- NOP_WORD, 32'h00000000: instruction word inserted into IF/ID on flush, squash or reset.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- PC  in  32  current PC register output.
- Instruction  in  32  instruction-memory read data at PC (combinational).
- Stall  in  1  hazard unit: hold PC and IF/ID.
- Flush  in  1  discard IF/ID contents; PC still advances.
- BranchTaken  in  1  resolved taken branch.
- BranchTarget  in  32  branch target byte address.
- Jump  in  1  resolved jump.
- JumpTarget  in  32  jump target byte address.
- NextAddress  out  32  to PC register Address input (combinational).
- IF_ID_Instruction  out  32  registered instruction to decode.
- IF_ID_PC4  out  32  registered PC+4 of that instruction.
- IF_ID_Valid  out  1  registered: IF/ID holds a real instruction.
- Squash  out  1  registered: high for the cycle in which a redirect bubble occupies IF/ID.

Behaviour:
- State machine: S_INIT, S_RUN, S_STALL, S_SQUASH. Registered state, 2 bits.
- Redirect is defined as Jump | BranchTaken.
- Reset (sampled at posedge Clk):
  - state <= S_INIT
  - IF_ID_Instruction <= NOP_WORD
  - IF_ID_PC4 <= 0
  - IF_ID_Valid <= 0
  - Squash <= 0
- NextAddress selection (combinational), priority order:
  1. state == S_INIT: 0.
  2. Jump: JumpTarget.
  3. BranchTaken: BranchTarget.
  4. Stall: PC (hold).
  5. Otherwise: PC + 4, computed in 32 bits with carry discarded.
  - After selection, if the result is greater than ADDR_LIMIT, NextAddress is 0.
  - Jump beats BranchTaken when both are high.
  - Redirect beats Stall.
- IF/ID register update (posedge, Reset not asserted), priority order:
  1. S_INIT: load NOP_WORD, Valid 0; go to S_RUN. This is exactly one bubble after reset, covering the PC's post-reset hold cycle.
  2. Redirect: load NOP_WORD, Valid 0, Squash 1; go to S_SQUASH. The wrong-path instruction fetched this cycle is discarded.
  3. Flush (no redirect): load NOP_WORD, Valid 0, Squash 0; state S_RUN.
  4. Stall: IF/ID and Squash hold; state S_STALL.
  5. Otherwise: load Instruction, PC + 4 (no wrap applied to IF_ID_PC4), Valid 1, Squash 0; state S_RUN.
- S_SQUASH lasts exactly one cycle unless a new redirect arrives, in which case it re-enters S_SQUASH and Squash stays 1.
- S_STALL exits when Stall drops.
  - The first cycle after the stall latches the instruction at the held PC.
  - No instruction is lost or duplicated.
- Simultaneous Stall & Flush without redirect: Flush wins; IF/ID becomes a bubble and PC holds.
- Reset asserted mid-stall or mid-squash overrides everything within the same cycle.
- Latency: instruction at PC appears on IF_ID_Instruction one posedge after it is presented.
- Redirect penalty: exactly 1 bubble.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output ports BubbleCount [15:0] and StallCount [15:0], both registered and cleared by Reset.
  - BubbleCount increments on every cycle IF_ID_Valid is loaded 0, excluding S_INIT.
  - StallCount increments on every cycle Stall holds IF/ID.
  - Both saturate at 16'hFFFF; no wrap.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset:
  - Stimulus: hold Reset 2 cycles, release; PC=0, Instruction=32'h20080005.
  - Required: Valid=0 the first cycle after release, NextAddress=0; next posedge gives IF_ID_Instruction=32'h20080005, IF_ID_PC4=4, Valid=1.
- Sequential wrap:
  - Stimulus: run with PC=32, then PC=36.
  - Required: NextAddress=36, then 0 (40 > ADDR_LIMIT); IF_ID_PC4 for PC=36 reads 40.
- Branch squash:
  - Stimulus: BranchTaken=1, BranchTarget=8 at PC=16.
  - Required: NextAddress=8; next cycle IF_ID_Instruction=NOP_WORD, Valid=0, Squash=1; following cycle the instruction from 8 appears with PC4=12, Squash=0.
- Jump vs branch:
  - Stimulus: Jump=1 (JumpTarget=20) and BranchTaken=1 (BranchTarget=4) together.
  - Required: NextAddress=20, one bubble.
- Stall hold/release:
  - Stimulus: Stall for 3 cycles at PC=12.
  - Required: NextAddress=12 each cycle; IF/ID unchanged; after release, instruction at 12 latched once with PC4=16.
- Flush+Stall and mid-stall reset:
  - Stimulus: Flush&Stall together, then Reset during a stall.
  - Required: first gives Valid=0 with NextAddress=PC; second gives all outputs at reset values the next cycle.
